// File: rtl/alu_scan_master.sv
// Command/response front end for the bit-serial ALU scan harness: serialises the
// operation over tdi, pulses sample, then collects the result bits from tdo.
//
// state   | meaning
// IDLE    | waiting for a command (cmd_ready high)
// SHIFT   | sending {op2, op1, w, funct3, ashr, sub} MSB first on tdi
// SAMPLE  | one-cycle sample strobe to the harness
// WAIT    | one cycle while tdo still holds a stale bit
// CAPTURE | shifting ltu, lt, eq, result[XLEN-1:0] in from tdo
// RESP    | response held until rsp_ready
module alu_scan_master #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_sub,
  input  logic            cmd_ashr,
  input  logic [2:0]      cmd_funct3,
  input  logic            cmd_w,
  input  logic [XLEN-1:0] cmd_op1,
  input  logic [XLEN-1:0] cmd_op2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_eq,
  output logic            rsp_lt,
  output logic            rsp_ltu,
  output logic            tdi,
  output logic            sample,
  input  logic            tdo
);

  localparam int SLEN = 2 * XLEN + 6;
  localparam int CLEN = XLEN + 3;
  localparam int CW   = $clog2(SLEN + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    SAMPLE  = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t            state;
  logic [SLEN-1:0]   s_reg;
  logic [CLEN-1:0]   c_reg;
  logic [CW-1:0]     cnt;

  // All serial-link and handshake outputs decode registered state only.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign tdi       = (state == SHIFT) && s_reg[SLEN-1];
  assign sample    = (state == SAMPLE);
  assign {rsp_ltu, rsp_lt, rsp_eq, rsp_result} = c_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s_reg <= '0;
      c_reg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            s_reg <= {cmd_op2, cmd_op1, cmd_w, cmd_funct3, cmd_ashr, cmd_sub};
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          s_reg <= s_reg << 1;
          if (cnt == CW'(SLEN - 1)) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt   <= '0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          c_reg <= {c_reg[CLEN-2:0], tdo};
          if (cnt == CW'(CLEN - 1)) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scan_master.sv
// Bench for alu_scan_master: a behavioural bit-serial ALU harness on the scan link,
// a per-cycle reference model of the link/handshake timing, and directed scenarios.
module tb_alu_scan_master;

  localparam int XLEN = 64;
  localparam int SLEN = 2 * XLEN + 6;
  localparam int CLEN = XLEN + 3;
  localparam int LAT  = 3 * XLEN + 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_sub = 1'b0;
  logic            cmd_ashr = 1'b0;
  logic [2:0]      cmd_funct3 = 3'd0;
  logic            cmd_w = 1'b0;
  logic [XLEN-1:0] cmd_op1 = '0;
  logic [XLEN-1:0] cmd_op2 = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_eq, rsp_lt, rsp_ltu;
  logic            tdi, sample, tdo;

  int n_chk  = 0;
  int n_fail = 0;

  alu_scan_master #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sub(cmd_sub), .cmd_ashr(cmd_ashr), .cmd_funct3(cmd_funct3), .cmd_w(cmd_w),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .rsp_ltu(rsp_ltu),
    .tdi(tdi), .sample(sample), .tdo(tdo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ALU reference: returns {ltu, lt, eq, result}.
  function automatic logic [66:0] alu(input logic sub, input logic ashr, input logic [2:0] f3,
                                      input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic eq, lt, ltu;
    int sh;
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    sh  = int'(b[5:0]);
    case (f3)
      3'd0: r = sub ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = {63'd0, lt};
      3'd3: r = {63'd0, ltu};
      3'd4: r = a ^ b;
      3'd5: r = ashr ? 64'($signed(a) >>> sh) : a >> sh;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return {ltu, lt, eq, r};
  endfunction

  // Scan harness: shifts tdi in, computes on sample, streams the result out MSB first
  // through a registered tdo (one stale bit right after sample).
  logic [SLEN-1:0] h_in  = '0;
  logic [CLEN-1:0] h_out = '0;
  logic            h_tdo = 1'b0;
  assign tdo = h_tdo;

  always @(posedge clk) begin
    if (sample) begin
      h_out <= alu(h_in[0], h_in[1], h_in[4:2], h_in[5], h_in[69:6], h_in[133:70]);
    end else begin
      h_in  <= {h_in[SLEN-2:0], tdi};
      h_out <= h_out << 1;
    end
    h_tdo <= h_out[CLEN-1];
  end

  // Reference model: p = clock edges since the accept edge.
  bit              busy = 1'b0;
  int              p = 0;
  logic [SLEN-1:0] exp_stream = '0;
  logic [CLEN-1:0] exp_c = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_tdi", tdi, 0);
      chk("rst_sample", sample, 0);
    end else begin
      if (busy) begin
        chk("m_tdi", tdi, (p < SLEN) ? exp_stream[SLEN-1-p] : 1'b0);
        chk("m_sample", sample, p == SLEN);
        chk("m_rsp_valid", rsp_valid, p >= LAT);
        chk("m_cmd_ready", cmd_ready, 0);
        if (p >= LAT) begin
          chk("m_result", rsp_result, exp_c[63:0]);
          chk("m_flags", {rsp_ltu, rsp_lt, rsp_eq}, exp_c[66:64]);
        end
        if (p >= LAT && rsp_ready) busy = 1'b0;
        else p++;
      end else begin
        chk("m_idle_ready", cmd_ready, 1);
        chk("m_idle_rsp_valid", rsp_valid, 0);
        chk("m_idle_tdi", tdi, 0);
        chk("m_idle_sample", sample, 0);
        if (cmd_valid) begin
          busy = 1'b1;
          p = 0;
          exp_stream = {cmd_op2, cmd_op1, cmd_w, cmd_funct3, cmd_ashr, cmd_sub};
          exp_c = alu(cmd_sub, cmd_ashr, cmd_funct3, cmd_w, cmd_op1, cmd_op2);
        end
      end
    end
  end

  task automatic drive(input logic sub, input logic ashr, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    cmd_sub = sub; cmd_ashr = ashr; cmd_funct3 = f3; cmd_w = w;
    cmd_op1 = a;   cmd_op2 = b;    cmd_valid = 1'b1;
  endtask

  // Returns just after the accept edge.
  task automatic wait_accept();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("accept_timeout", cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  // Called just after the accept edge; returns at the negedge where rsp_valid first shows.
  task automatic wait_rsp(output logic [66:0] c, output int lat, output int tcnt,
                          output int tfirst, output int scnt, output int spos);
    lat = 0; tcnt = 0; tfirst = -1; scnt = 0; spos = -1;
    forever begin
      @(negedge clk);
      if (tdi) begin
        if (tfirst < 0) tfirst = lat;
        tcnt++;
      end
      if (sample) begin
        scnt++;
        spos = lat;
      end
      if (rsp_valid || lat >= 400) break;
      @(posedge clk);
      lat++;
    end
    chk("rsp_timeout", rsp_valid, 1);
    c = {rsp_ltu, rsp_lt, rsp_eq, rsp_result};
  endtask

  // Holds off rsp_ready for bp cycles, then completes the handshake.
  task automatic finish_rsp(input int bp, input logic [66:0] c);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_stable", {rsp_ltu, rsp_lt, rsp_eq, rsp_result}, c);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_cmd_ready", cmd_ready, 1);
  endtask

  task automatic run_one(input logic sub, input logic ashr, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input int bp,
                         output logic [66:0] c, output int lat, output int tcnt,
                         output int tfirst, output int scnt, output int spos);
    @(posedge clk); #1;
    drive(sub, ashr, f3, w, a, b);
    wait_accept();
    cmd_valid = 1'b0;
    cmd_op1 = ~a; cmd_op2 = ~b; cmd_funct3 = ~f3; cmd_sub = ~sub;
    wait_rsp(c, lat, tcnt, tfirst, scnt, spos);
    finish_rsp(bp, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [66:0] c;
    int lat, tcnt, tfirst, scnt, spos;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_tdi", tdi, 0);
    chk("reset_sample", sample, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);

    // ADD 5 + 7
    run_one(0, 0, 3'd0, 0, 64'd5, 64'd7, 1, c, lat, tcnt, tfirst, scnt, spos);
    chk("add_result", c[63:0], 64'd12);
    chk("add_flags", c[66:64], 3'b110);
    chk("add_latency", lat, LAT);

    // SUB equal operands
    run_one(1, 0, 3'd0, 0, 64'h10, 64'h10, 1, c, lat, tcnt, tfirst, scnt, spos);
    chk("sub_result", c[63:0], 64'd0);
    chk("sub_flags", c[66:64], 3'b001);
    chk("sub_latency", lat, LAT);

    // Bit order: only op2 MSB set
    run_one(0, 0, 3'd0, 0, 64'd0, 64'h8000000000000000, 1, c, lat, tcnt, tfirst, scnt, spos);
    chk("bo_tdi_first", tfirst, 0);
    chk("bo_tdi_count", tcnt, 1);
    chk("bo_sample_count", scnt, 1);
    chk("bo_sample_pos", spos, SLEN);
    chk("bo_result", c[63:0], 64'h8000000000000000);
    chk("bo_flags", c[66:64], 3'b100);

    // Word add with sign extension, arithmetic shift right
    run_one(0, 0, 3'd0, 1, 64'h7fffffff, 64'd1, 1, c, lat, tcnt, tfirst, scnt, spos);
    chk("addw_result", c[63:0], 64'hffffffff80000000);
    run_one(0, 1, 3'd5, 0, 64'h8000000000000000, 64'd4, 1, c, lat, tcnt, tfirst, scnt, spos);
    chk("sra_result", c[63:0], 64'hf800000000000000);
    chk("sra_flags", c[66:64], 3'b010);

    // Backpressure: 10 cycles with rsp_ready low
    run_one(0, 0, 3'd4, 0, 64'hff00ff00ff00ff00, 64'h0ff00ff00ff00ff0, 10,
            c, lat, tcnt, tfirst, scnt, spos);
    chk("bp_result", c[63:0], 64'hf0f0f0f0f0f0f0f0);

    // Reset in SHIFT cycle 50, then a fresh command
    @(posedge clk); #1;
    drive(0, 0, 3'd6, 0, 64'h1234, 64'h5678);
    wait_accept();
    cmd_valid = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_tdi", tdi, 0);
    chk("midrst_sample", sample, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    run_one(0, 0, 3'd0, 0, 64'hffffffffffffffff, 64'd1, 1, c, lat, tcnt, tfirst, scnt, spos);
    chk("postrst_result", c[63:0], 64'd0);
    chk("postrst_latency", lat, LAT);

    // Back-to-back: cmd_valid stays high with the second command queued
    @(posedge clk); #1;
    drive(0, 0, 3'd0, 0, 64'd100, 64'd23);
    wait_accept();
    drive(1, 0, 3'd0, 0, 64'd3, 64'd10);
    wait_rsp(c, lat, tcnt, tfirst, scnt, spos);
    chk("b2b_first_result", c[63:0], 64'd123);
    finish_rsp(1, c);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(c, lat, tcnt, tfirst, scnt, spos);
    chk("b2b_second_latency", lat, LAT);
    chk("b2b_second_result", c[63:0], 64'hfffffffffffffff9);
    chk("b2b_second_flags", c[66:64], 3'b110);
    finish_rsp(1, c);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
